// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencer for the 5-stage in-order core.
//
// Produces stall/flush controls for the F/D, D/E and E/M pipeline registers,
// the execute-stage ALU operand forwarding selects, and the start pulse for
// the iterative mul/div unit. Keeps saturating stall/flush counters.
//
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   ad1d, ad2d               decode-stage source addresses
//   ad1e, ad2e, rde          execute-stage sources / destination
//   regWrte, resltSrce       execute-stage write enable, result select (01 = load)
//   pcSrce                   taken branch/jump resolved in execute
//   mdStarte, mdDone         mul/div op in execute, unit result-valid pulse
//   rdm, rdw, regWrtm/w      memory/writeback destinations and write enables
//   stallF/D/E               hold PC, F/D, D/E
//   flushD/E/M               bubble into F/D, D/E, E/M
//   fwdAe, fwdBe             00 = regfile, 01 = writeback, 10 = memory
//   mdGo                     one-cycle start pulse to the mul/div unit
//   stallCnt, flushCnt       saturating performance counters
//
// All control outputs are combinational from inputs and the FSM state; the
// FSM state and the two counters are the only registers.

// Forwarding select for one ALU operand. Memory stage has priority because
// it holds the younger result.
module hazard_fwd (
    input  logic       clr,
    input  logic [4:0] ad,
    input  logic [4:0] rdm,
    input  logic [4:0] rdw,
    input  logic       regWrtm,
    input  logic       regWrtw,
    output logic [1:0] sel
);
    always_comb begin
        sel = 2'b00;
        if (!clr) begin
            if (regWrtm && rdm != 5'd0 && rdm == ad)
                sel = 2'b10;
            else if (regWrtw && rdw != 5'd0 && rdw == ad)
                sel = 2'b01;
        end
    end
endmodule

module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       ad1d,
    input  logic [4:0]       ad2d,
    input  logic [4:0]       ad1e,
    input  logic [4:0]       ad2e,
    input  logic [4:0]       rde,
    input  logic             regWrte,
    input  logic [1:0]       resltSrce,
    input  logic             pcSrce,
    input  logic             mdStarte,
    input  logic             mdDone,
    input  logic [4:0]       rdm,
    input  logic [4:0]       rdw,
    input  logic             regWrtm,
    input  logic             regWrtw,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [1:0]       fwdAe,
    output logic [1:0]       fwdBe,
    output logic             mdGo,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);
    localparam int NUM_SRC = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, BUSY} md_state_t;
    md_state_t state;

    // ---------------- forwarding ----------------
    logic [NUM_SRC-1:0][4:0] src;
    logic [NUM_SRC-1:0][1:0] fsel;

    assign src = {ad2e, ad1e};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        hazard_fwd u_fwd (
            .clr     (clr),
            .ad      (src[i]),
            .rdm     (rdm),
            .rdw     (rdw),
            .regWrtm (regWrtm),
            .regWrtw (regWrtw),
            .sel     (fsel[i])
        );
    end

    assign fwdAe = fsel[0];
    assign fwdBe = fsel[1];

    // ---------------- hazards ----------------
    logic lwStall;
    logic mdHold;

    assign lwStall = regWrte && resltSrce == 2'b01 && rde != 5'd0 &&
                     (rde == ad1d || rde == ad2d);

    // Execute is held from the mdGo cycle until (not including) the mdDone
    // cycle; in the mdDone cycle E/M captures the result normally.
    assign mdHold = (state == IDLE) ? mdStarte : !mdDone;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        mdGo   = 1'b0;
        if (clr) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (mdHold) begin
            // md stall masks load-use and branch handling entirely
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
            mdGo   = (state == IDLE);
        end else begin
            // load-use and branch may coincide; the stalled decode
            // instruction is discarded by the flush
            stallF = lwStall;
            stallD = lwStall;
            flushD = pcSrce;
            flushE = pcSrce || lwStall;
        end
    end

    // ---------------- state and counters ----------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            case (state)
                IDLE: if (mdStarte) state <= BUSY;
                BUSY: if (mdDone)   state <= IDLE;
                default:            state <= IDLE;
            endcase
            if (stallF && stallCnt != CNT_MAX)
                stallCnt <= stallCnt + CNT_ONE;
            if ((flushD || flushE) && flushCnt != CNT_MAX)
                flushCnt <= flushCnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic [4:0] ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw;
    logic       regWrte, regWrtm, regWrtw, pcSrce, mdStarte, mdDone;
    logic [1:0] resltSrce;

    logic        stallF, stallD, stallE, flushD, flushE, flushM, mdGo;
    logic [1:0]  fwdAe, fwdBe;
    logic [31:0] stallCnt, flushCnt;

    logic        s4F, s4D, s4E, f4D, f4E, f4M, go4;
    logic [1:0]  fa4, fb4;
    logic [3:0]  stallCnt4, flushCnt4;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .clr(clr), .ad1d(ad1d), .ad2d(ad2d), .ad1e(ad1e), .ad2e(ad2e),
        .rde(rde), .regWrte(regWrte), .resltSrce(resltSrce), .pcSrce(pcSrce),
        .mdStarte(mdStarte), .mdDone(mdDone), .rdm(rdm), .rdw(rdw),
        .regWrtm(regWrtm), .regWrtw(regWrtw), .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .fwdAe(fwdAe), .fwdBe(fwdBe), .mdGo(mdGo), .stallCnt(stallCnt),
        .flushCnt(flushCnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .clr(clr), .ad1d(ad1d), .ad2d(ad2d), .ad1e(ad1e), .ad2e(ad2e),
        .rde(rde), .regWrte(regWrte), .resltSrce(resltSrce), .pcSrce(pcSrce),
        .mdStarte(mdStarte), .mdDone(mdDone), .rdm(rdm), .rdw(rdw),
        .regWrtm(regWrtm), .regWrtw(regWrtw), .stallF(s4F), .stallD(s4D),
        .stallE(s4E), .flushD(f4D), .flushE(f4E), .flushM(f4M),
        .fwdAe(fa4), .fwdBe(fb4), .mdGo(go4), .stallCnt(stallCnt4),
        .flushCnt(flushCnt4)
    );

    int tot = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        bit       sF, sD, sE, fD, fE, fM, go;
        bit [1:0] fa, fb;
    } exp_t;

    bit     m_busy = 1'b0;   // an md op has been launched and not yet completed
    longint m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;

    function automatic bit [1:0] fwd_of(input bit [4:0] a);
        if (a == 0)                                   return 2'b00;
        if (regWrtm && rdm == a)                      return 2'b10;
        if (regWrtw && rdw == a)                      return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model();
        exp_t e;
        bit   hold, lw;
        e = '0;
        if (clr) begin
            e.fD = 1; e.fE = 1; e.fM = 1;
            return e;
        end
        hold = m_busy ? !mdDone : mdStarte;
        lw   = regWrte && resltSrce == 2'b01 && rde != 0 && (rde == ad1d || rde == ad2d);
        if (hold) begin
            e.sF = 1; e.sD = 1; e.sE = 1; e.fM = 1;
            e.go = !m_busy;
        end else begin
            e.sF = lw; e.sD = lw;
            e.fD = pcSrce;
            e.fE = pcSrce || lw;
        end
        e.fa = fwd_of(ad1e);
        e.fb = fwd_of(ad2e);
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = model();
        if (clr) begin
            m_busy = 0; m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        end else begin
            if (e.sF) begin
                if (m_sc < 64'h0FFFFFFFF) m_sc++;
                if (m_sc4 < 15) m_sc4++;
            end
            if (e.fD || e.fE) begin
                if (m_fc < 64'h0FFFFFFFF) m_fc++;
                if (m_fc4 < 15) m_fc4++;
            end
            if (!m_busy && mdStarte)    m_busy = 1;
            else if (m_busy && mdDone)  m_busy = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = model();
            chk("m_stallF", stallF, e.sF);
            chk("m_stallD", stallD, e.sD);
            chk("m_stallE", stallE, e.sE);
            chk("m_flushD", flushD, e.fD);
            chk("m_flushE", flushE, e.fE);
            chk("m_flushM", flushM, e.fM);
            chk("m_mdGo",   mdGo,   e.go);
            chk("m_fwdAe",  fwdAe,  e.fa);
            chk("m_fwdBe",  fwdBe,  e.fb);
            chk("m_stallCnt", stallCnt, m_sc);
            chk("m_flushCnt", flushCnt, m_fc);
            chk("m4_stallF", s4F, e.sF);
            chk("m4_stallE", s4E, e.sE);
            chk("m4_flushE", f4E, e.fE);
            chk("m4_mdGo",   go4, e.go);
            chk("m4_stallCnt", stallCnt4, m_sc4);
            chk("m4_flushCnt", flushCnt4, m_fc4);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero();
        clr = 0; ad1d = 0; ad2d = 0; ad1e = 0; ad2e = 0; rde = 0; rdm = 0; rdw = 0;
        regWrte = 0; regWrtm = 0; regWrtw = 0; pcSrce = 0; mdStarte = 0; mdDone = 0;
        resltSrce = 0;
    endtask

    task automatic set_lw();
        regWrte = 1; resltSrce = 2'b01; rde = 5; ad1d = 5;
    endtask

    initial begin
        zero();
        // reset with every hazard source active: reset values must win
        clr = 1; regWrtm = 1; rdm = 7; ad1e = 7; pcSrce = 1; mdStarte = 1; set_lw();
        #3;
        chk("rst_flushD", flushD, 1); chk("rst_flushE", flushE, 1);
        chk("rst_flushM", flushM, 1); chk("rst_stallF", stallF, 0);
        chk("rst_stallE", stallE, 0); chk("rst_mdGo", mdGo, 0);
        chk("rst_fwdAe", fwdAe, 0);
        cyc(); zero(); cmp_en = 1; #2;
        chk("rst_stallCnt", stallCnt, 0); chk("rst_flushCnt", flushCnt, 0);

        // load-use
        cyc(); set_lw(); #2;
        chk("lw_stallF", stallF, 1); chk("lw_stallD", stallD, 1);
        chk("lw_flushE", flushE, 1); chk("lw_flushD", flushD, 0); chk("lw_stallE", stallE, 0);
        cyc(); zero(); #2;
        chk("lw_stallCnt", stallCnt, 1); chk("lw_flushCnt", flushCnt, 1);
        chk("lw_release", stallF, 0);
        cyc(); regWrte = 1; resltSrce = 2'b01; #2;      // rde = ad1d = 0
        chk("lw_x0_stallF", stallF, 0); chk("lw_x0_flushE", flushE, 0);
        cyc(); rde = 9; ad2d = 9; resltSrce = 2'b10; #2;
        chk("nonload_stallF", stallF, 0);
        cyc(); resltSrce = 2'b01; #2;
        chk("lw_src2_stallF", stallF, 1);               // stall 2, flush 2

        // forwarding
        cyc(); zero(); regWrtm = 1; regWrtw = 1; rdm = 7; rdw = 7; ad1e = 7; ad2e = 7; #2;
        chk("fwd_mem_A", fwdAe, 2'b10); chk("fwd_mem_B", fwdBe, 2'b10);
        cyc(); regWrtm = 0; #2;
        chk("fwd_wb_A", fwdAe, 2'b01); chk("fwd_wb_B", fwdBe, 2'b01);
        cyc(); rdw = 0; ad2e = 0; #2;
        chk("fwd_x0_B", fwdBe, 2'b00); chk("fwd_none_A", fwdAe, 2'b00);
        cyc(); regWrtm = 1; rdm = 3; rdw = 4; ad1e = 4; ad2e = 3; #2;
        chk("fwd_split_A", fwdAe, 2'b01); chk("fwd_split_B", fwdBe, 2'b10);

        // branch, then branch + load-use together
        cyc(); zero(); pcSrce = 1; #2;
        chk("br_flushD", flushD, 1); chk("br_flushE", flushE, 1); chk("br_stallF", stallF, 0);
        cyc(); zero(); #2;
        chk("br_flushCnt", flushCnt, 3); chk("br_stallCnt", stallCnt, 2);
        cyc(); pcSrce = 1; set_lw(); #2;
        chk("brlw_stallF", stallF, 1); chk("brlw_flushD", flushD, 1); chk("brlw_flushE", flushE, 1);
        cyc(); zero(); #2;
        chk("brlw_stallCnt", stallCnt, 3); chk("brlw_flushCnt", flushCnt, 4);

        // md op, latency 3, with a branch pulse while busy
        cyc(); mdStarte = 1; #2;
        chk("md_go", mdGo, 1); chk("md_stallE0", stallE, 1); chk("md_flushM0", flushM, 1);
        chk("md_flushD0", flushD, 0);
        cyc(); pcSrce = 1; #2;
        chk("md_go_once", mdGo, 0); chk("md_stallE1", stallE, 1);
        chk("md_br_flushD", flushD, 0); chk("md_br_flushE", flushE, 0);
        cyc(); pcSrce = 0; #2;
        chk("md_stallE2", stallE, 1); chk("md_flushM2", flushM, 1);
        cyc(); mdStarte = 0; mdDone = 1; #2;
        chk("md_done_stallE", stallE, 0); chk("md_done_flushM", flushM, 0);
        chk("md_done_stallF", stallF, 0); chk("md_done_go", mdGo, 0);
        cyc(); zero(); #2;
        chk("md_stallCnt", stallCnt, 6); chk("md_flushCnt", flushCnt, 4);

        // back-to-back md ops, latency 1 each
        cyc(); mdStarte = 1; #2;
        chk("b2b_go0", mdGo, 1);
        cyc(); mdDone = 1; #2;
        chk("b2b_done0", stallE, 0);
        cyc(); mdDone = 0; #2;
        chk("b2b_go1", mdGo, 1);
        cyc(); mdStarte = 0; mdDone = 1; #2;
        chk("b2b_done1", stallE, 0);
        cyc(); zero(); #2;
        chk("b2b_stallCnt", stallCnt, 8);

        // stray mdDone in IDLE
        cyc(); mdDone = 1; #2;
        chk("idle_done_stallE", stallE, 0); chk("idle_done_go", mdGo, 0);
        cyc(); mdDone = 0; #2;
        chk("idle_after_stallE", stallE, 0);

        // reset while busy abandons the op
        cyc(); mdStarte = 1; #2;
        chk("clr_md_go", mdGo, 1);
        cyc(); mdStarte = 0; clr = 1; #2;
        chk("clr_busy_stallE", stallE, 0); chk("clr_busy_flushD", flushD, 1);
        cyc(); clr = 0; #2;
        chk("clr_idle_stallE", stallE, 0); chk("clr_idle_go", mdGo, 0);
        chk("clr_stallCnt", stallCnt, 0); chk("clr_flushCnt", flushCnt, 0);
        cyc(); mdStarte = 1; #2;
        chk("clr_fresh_go", mdGo, 1);
        cyc(); mdStarte = 0; mdDone = 1; #2;
        chk("clr_fresh_done", stallE, 0);

        // saturation: 20 load-use cycles on top of the 1 md stall above
        cyc(); zero(); set_lw();
        repeat (20) cyc();
        zero(); #2;
        chk("sat_stallCnt32", stallCnt, 21); chk("sat_flushCnt32", flushCnt, 20);
        chk("sat_stallCnt4", stallCnt4, 15); chk("sat_flushCnt4", flushCnt4, 15);

        cyc(); cyc();
        cmp_en = 0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
